// File: rtl/ps2_hex_keypad.sv
// PS/2 keyboard receiver that tracks make/break scan-code state and reports
// the sixteen hex keys as a 4-bit code with held level and new-key strobe.
module ps2_hex_keypad #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps_clk,
    input  logic       ps_dat,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic       key_valid,
    output logic       frame_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BRK     = 2'd1;
    localparam logic [1:0] EXT     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYC);

    logic        clk_s1, clk_s2, clk_prev;
    logic        dat_s1, dat_s2;
    logic [3:0]  bit_cnt;
    logic [19:0] timer;
    logic [9:0]  shreg;
    logic [7:0]  byte_reg;
    logic        byte_vld;
    logic [1:0]  state;

    logic [10:0] frame;
    logic        fall;
    logic        last_bit;
    logic        frame_good;
    logic [4:0]  map_res;

    // Scan code to {mapped, hex value}
    function automatic logic [4:0] hex_map(input logic [7:0] sc);
        case (sc)
            8'h45:   hex_map = {1'b1, 4'h0};
            8'h16:   hex_map = {1'b1, 4'h1};
            8'h1E:   hex_map = {1'b1, 4'h2};
            8'h26:   hex_map = {1'b1, 4'h3};
            8'h25:   hex_map = {1'b1, 4'h4};
            8'h2E:   hex_map = {1'b1, 4'h5};
            8'h36:   hex_map = {1'b1, 4'h6};
            8'h3D:   hex_map = {1'b1, 4'h7};
            8'h3E:   hex_map = {1'b1, 4'h8};
            8'h46:   hex_map = {1'b1, 4'h9};
            8'h1C:   hex_map = {1'b1, 4'hA};
            8'h32:   hex_map = {1'b1, 4'hB};
            8'h21:   hex_map = {1'b1, 4'hC};
            8'h23:   hex_map = {1'b1, 4'hD};
            8'h24:   hex_map = {1'b1, 4'hE};
            8'h2B:   hex_map = {1'b1, 4'hF};
            default: hex_map = 5'd0;
        endcase
    endfunction

    // frame holds the full 11 bits on the last edge: bit 0 = start, bit 10 = stop
    assign frame      = {dat_s2, shreg};
    assign fall       = clk_prev & ~clk_s2;
    assign last_bit   = fall && (bit_cnt == 4'd10);
    assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);
    assign map_res    = hex_map(byte_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            clk_prev  <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            bit_cnt   <= 4'd0;
            timer     <= 20'd0;
            shreg     <= 10'd0;
            byte_reg  <= 8'd0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s1    <= ps_clk;
            clk_s2    <= clk_s1;
            clk_prev  <= clk_s2;
            dat_s1    <= ps_dat;
            dat_s2    <= dat_s1;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                timer <= 20'd0;
                shreg <= frame[10:1];
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_good) begin
                        byte_reg <= frame[8:1];
                        byte_vld <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned so the next start bit realigns
                if (timer == TIMEOUT_VAL) begin
                    bit_cnt   <= 4'd0;
                    timer     <= 20'd0;
                    frame_err <= 1'b1;
                end else begin
                    timer <= timer + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            key_code    <= 4'd0;
            key_pressed <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (last_bit && !frame_good) begin
                state <= IDLE;
            end else if (byte_vld) begin
                case (state)
                    IDLE: begin
                        if (byte_reg == 8'hE0) begin
                            state <= EXT;
                        end else if (byte_reg == 8'hF0) begin
                            state <= BRK;
                        end else if (map_res[4] &&
                                     !(key_pressed && map_res[3:0] == key_code)) begin
                            key_code    <= map_res[3:0];
                            key_pressed <= 1'b1;
                            key_valid   <= 1'b1;
                        end
                    end
                    BRK: begin
                        if (map_res[4] && key_pressed && map_res[3:0] == key_code)
                            key_pressed <= 1'b0;
                        state <= IDLE;
                    end
                    EXT: begin
                        state <= (byte_reg == 8'hF0) ? EXT_BRK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_hex_keypad.sv
// Directed bench for ps2_hex_keypad: a byte-level keyboard model predicts the
// outputs, checked every cycle, plus literal expectations at scenario ends.
module tb_ps2_hex_keypad;

    localparam int T = 200;   // timeout used for this bench
    localparam int H = 10;    // half PS/2 bit period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps_clk = 1'b1;
    logic       ps_dat = 1'b1;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_valid;
    logic       frame_err;

    ps2_hex_keypad #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .ps_clk(ps_clk), .ps_dat(ps_dat),
        .key_code(key_code), .key_pressed(key_pressed),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    bit checking = 1'b1;

    // expected outputs and keyboard-protocol memory
    logic [3:0] exp_code = 4'd0;
    logic       exp_pressed = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_err = 1'b0;
    bit m_ext = 0, m_brk = 0, m_ext_brk = 0;
    int keymap [256];

    task automatic check(input string name, input int got, input int want);
        chk_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk_cnt++;
            if (key_code === exp_code && key_pressed === exp_pressed &&
                key_valid === exp_valid && frame_err === exp_err)
                pass_cnt++;
            else
                $display("FAIL cycle t=%0t: got code=%h pr=%b kv=%b fe=%b want code=%h pr=%b kv=%b fe=%b",
                         $time, key_code, key_pressed, key_valid, frame_err,
                         exp_code, exp_pressed, exp_valid, exp_err);
            if (key_valid === 1'b1) valid_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    task automatic model_reset();
        exp_code = 4'd0; exp_pressed = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
        m_ext = 0; m_brk = 0; m_ext_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = keymap[b];
        if (m_ext_brk) begin
            m_ext_brk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_ext_brk = 1;
        end else if (m_brk) begin
            m_brk = 0;
            if (k >= 0 && exp_pressed && k == int'(exp_code)) exp_pressed = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (k >= 0 && !(exp_pressed && k == int'(exp_code))) begin
            exp_code = 4'(k);
            exp_pressed = 1'b1;
            exp_valid = 1'b1;
        end
    endtask

    // Sends nbits of the frame for b; a full frame also schedules the model update
    task automatic send_bits(input logic [7:0] b, input bit flip, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps_dat = bits[i];
            repeat (H - 1) @(negedge clk);
            ps_clk = 1'b0;
            if (i == 10) begin
                if (!flip) begin
                    repeat (4) @(posedge clk);
                    #1 model_byte(b);
                    @(posedge clk);
                    #1 exp_valid = 1'b0;
                end else begin
                    repeat (3) @(posedge clk);
                    #1 begin exp_err = 1'b1; m_ext = 0; m_brk = 0; m_ext_brk = 0; end
                    @(posedge clk);
                    #1 exp_err = 1'b0;
                end
                repeat (H - 6) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            ps_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) keymap[i] = -1;
        keymap[8'h45] = 0;  keymap[8'h16] = 1;  keymap[8'h1E] = 2;  keymap[8'h26] = 3;
        keymap[8'h25] = 4;  keymap[8'h2E] = 5;  keymap[8'h36] = 6;  keymap[8'h3D] = 7;
        keymap[8'h3E] = 8;  keymap[8'h46] = 9;  keymap[8'h1C] = 10; keymap[8'h32] = 11;
        keymap[8'h21] = 12; keymap[8'h23] = 13; keymap[8'h24] = 14; keymap[8'h2B] = 15;
        model_reset();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_code", key_code, 0);
        check("reset_pressed", key_pressed, 0);

        send(8'h16);
        check("k16_code", key_code, 1);
        check("k16_pressed", key_pressed, 1);
        check("k16_strobes", valid_seen, 1);

        send(8'h16); send(8'hF0); send(8'h16);
        check("rel16_pressed", key_pressed, 0);
        check("rel16_code", key_code, 1);
        check("rel16_strobes", valid_seen, 1);

        send(8'h1C); send(8'h2B); send(8'hF0); send(8'h1C);
        check("rollover_code", key_code, 15);
        check("rollover_pressed", key_pressed, 1);
        send(8'hF0); send(8'h2B);
        check("rel2B_pressed", key_pressed, 0);

        send_bits(8'h45, 1'b1, 11);
        check("parity_err_count", err_seen, 1);
        check("parity_code", key_code, 15);
        send(8'h45);
        check("k45_code", key_code, 0);

        // partial frame, then wait out the timeout
        send_bits(8'h46, 1'b0, 6);
        repeat (4 + T - 2 * H) @(posedge clk);
        #1 exp_err = 1'b1;
        @(posedge clk);
        #1 exp_err = 1'b0;
        repeat (20) @(negedge clk);
        check("timeout_err_count", err_seen, 2);
        send(8'h46);
        check("k46_code", key_code, 9);

        send(8'hE0); send(8'h16);
        send(8'hE0); send(8'hF0); send(8'h16);
        send(8'h5A);
        check("ext_code", key_code, 9);
        check("ext_pressed", key_pressed, 1);

        send_bits(8'h26, 1'b0, 5);
        @(posedge clk);
        #1 begin rst = 1'b1; model_reset(); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_code", key_code, 0);
        check("midrst_pressed", key_pressed, 0);
        send(8'h26);
        check("k26_code", key_code, 3);
        check("k26_pressed", key_pressed, 1);
        check("total_strobes", valid_seen, 6);
        check("total_errs", err_seen, 2);

        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
